// File: rtl/maindec_pkg.sv
// Shared types for the multicycle main decoder: state encoding, opcodes,
// control field encodings and the packed datapath control bundle.
package maindec_pkg;

  typedef enum logic [4:0] {
    S_FETCH, S_FETCHWAIT, S_DECODE,
    S_MEMADR, S_MEMREAD, S_MEMREADWAIT, S_MEMWRITEBACK, S_MEMWRITE,
    S_EXECUTE, S_ALUWRITEBACK, S_BRANCH, S_IMMEXECUTE, S_IMMWRITEBACK,
    S_LUIEX, S_AUIPCEX, S_JALEX, S_JALREX,
    S_SENDB_GO, S_SENDB_WAIT, S_RECVB_GO, S_RECVB_WAIT, S_RECVB_WRITE,
    S_TRAP
  } statetype;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_RECVB = 7'b0000001;
  localparam logic [6:0] OP_SENDB = 7'b0000010;

  localparam logic [2:0] RS_MEM  = 3'b001;
  localparam logic [2:0] RS_IMM  = 3'b010;
  localparam logic [2:0] RS_PC4  = 3'b011;
  localparam logic [2:0] RS_UART = 3'b100;

  localparam logic [2:0] AOP_R  = 3'b100;
  localparam logic [2:0] AOP_I  = 3'b101;
  localparam logic [2:0] AOP_BR = 3'b111;

  localparam logic [1:0] PC_TGT = 2'b01;
  localparam logic [1:0] PC_ALU = 2'b10;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_UART    = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       pcbufwrite;
    logic       iord;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] regsrc;
    logic [1:0] pcsrc;
    logic       branch;
    logic [2:0] aluop;
    logic       rors;
    logic       uart_go;
  } ctrl_t;

endpackage

// File: rtl/maindec_param_if.sv
// Decoder <-> datapath bundle: opcode and UART completion in, control bundle out.
interface maindec_param_if;
  logic [6:0] op;
  logic       uart_done;
  logic       pcwrite, memwrite, irwrite, regwrite, pcbufwrite;
  logic       iord;
  logic [1:0] alusrca, alusrcb;
  logic [2:0] regsrc;
  logic [1:0] pcsrc;
  logic       branch;
  logic [2:0] aluop;
  logic       rors, uart_go;
  logic       halt;
  logic [1:0] trap_cause;

  modport master (
    input  op, uart_done,
    output pcwrite, memwrite, irwrite, regwrite, pcbufwrite, iord,
           alusrca, alusrcb, regsrc, pcsrc, branch, aluop, rors, uart_go,
           halt, trap_cause
  );

  modport slave (
    output op, uart_done,
    input  pcwrite, memwrite, irwrite, regwrite, pcbufwrite, iord,
           alusrca, alusrcb, regsrc, pcsrc, branch, aluop, rors, uart_go,
           halt, trap_cause
  );
endinterface

// File: rtl/maindec_param.sv
// Moore main decoder for the multicycle RV32I core with UART ops; memory latency,
// UART timeout and illegal-opcode trapping are parameters.
module maindec_param
  import maindec_pkg::*;
#(
  parameter int MEM_LAT         = 2,
  parameter int UART_TIMEOUT    = 0,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  maindec_param_if.master  bus
);

  localparam int TW = ($clog2(UART_TIMEOUT + 1) > 1) ? $clog2(UART_TIMEOUT + 1) : 1;
  localparam int TMO_LAST_I = (UART_TIMEOUT > 0) ? UART_TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_LAST_I);
  localparam logic [3:0]    LAT_LAST = 4'(MEM_LAT - 1);

  statetype      state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [1:0]    cause_q, cause_d;
  ctrl_t         ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      cause_q <= TC_NONE;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      cause_q <= cause_d;
    end
  end

  // Counters default to zero so any state exit clears them.
  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    tcnt_d  = '0;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:       state_d = S_FETCHWAIT;
      S_FETCHWAIT: begin
        if (wcnt_q == LAT_LAST) state_d = S_DECODE;
        else                    wcnt_d  = wcnt_q + 4'd1;
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTE;
          OP_B:         state_d = S_BRANCH;
          OP_I:         state_d = S_IMMEXECUTE;
          OP_LUI:       state_d = S_LUIEX;
          OP_AUIPC:     state_d = S_AUIPCEX;
          OP_JAL:       state_d = S_JALEX;
          OP_JALR:      state_d = S_JALREX;
          OP_RECVB:     state_d = S_RECVB_GO;
          OP_SENDB:     state_d = S_SENDB_GO;
          default: begin
            if (TRAP_ON_ILLEGAL != 0) begin
              state_d = S_TRAP;
              cause_d = TC_ILLEGAL;
            end else begin
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_LW)      state_d = S_MEMREAD;
        else if (bus.op == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD:     state_d = S_MEMREADWAIT;
      S_MEMREADWAIT: begin
        if (wcnt_q == LAT_LAST) state_d = S_MEMWRITEBACK;
        else                    wcnt_d  = wcnt_q + 4'd1;
      end
      S_EXECUTE:     state_d = S_ALUWRITEBACK;
      S_IMMEXECUTE:  state_d = S_IMMWRITEBACK;
      S_SENDB_GO:    state_d = S_SENDB_WAIT;
      S_RECVB_GO:    state_d = S_RECVB_WAIT;
      S_SENDB_WAIT, S_RECVB_WAIT: begin
        if (bus.uart_done) begin
          state_d = (state_q == S_SENDB_WAIT) ? S_FETCH : S_RECVB_WRITE;
        end else if (UART_TIMEOUT > 0 && tcnt_q == TMO_LAST) begin
          state_d = S_TRAP;
          cause_d = TC_UART;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_TRAP:        state_d = S_TRAP;
      default:       state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.pcwrite    = 1'b1;
        ctrl.pcbufwrite = 1'b1;
        ctrl.alusrcb    = 2'b01;
      end
      S_FETCHWAIT:    ctrl.irwrite = (wcnt_q == LAT_LAST);
      S_DECODE: begin
        ctrl.alusrca = 2'b01;
        ctrl.alusrcb = 2'b10;
      end
      S_MEMADR, S_IMMEXECUTE: begin
        ctrl.alusrca = 2'b10;
        ctrl.alusrcb = 2'b10;
        if (state_q == S_IMMEXECUTE) ctrl.aluop = AOP_I;
      end
      S_MEMREAD, S_MEMREADWAIT: ctrl.iord = 1'b1;
      S_MEMWRITEBACK: begin
        ctrl.regwrite = 1'b1;
        ctrl.regsrc   = RS_MEM;
      end
      S_MEMWRITE: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 2'b10;
        ctrl.aluop   = AOP_R;
      end
      S_ALUWRITEBACK, S_IMMWRITEBACK, S_AUIPCEX: ctrl.regwrite = 1'b1;
      S_BRANCH: begin
        ctrl.alusrca = 2'b10;
        ctrl.pcsrc   = PC_TGT;
        ctrl.branch  = 1'b1;
        ctrl.aluop   = AOP_BR;
      end
      S_LUIEX: begin
        ctrl.regwrite = 1'b1;
        ctrl.regsrc   = RS_IMM;
      end
      S_JALEX: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.regsrc   = RS_PC4;
        ctrl.pcsrc    = PC_TGT;
      end
      S_JALREX: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.alusrca  = 2'b10;
        ctrl.alusrcb  = 2'b10;
        ctrl.regsrc   = RS_PC4;
        ctrl.pcsrc    = PC_ALU;
      end
      S_SENDB_GO: begin
        ctrl.rors    = 1'b1;
        ctrl.uart_go = 1'b1;
      end
      S_SENDB_WAIT:   ctrl.uart_go = 1'b1;
      S_RECVB_GO:     ctrl.rors    = 1'b1;
      S_RECVB_WRITE: begin
        ctrl.regwrite = 1'b1;
        ctrl.regsrc   = RS_UART;
      end
      default:        ctrl = '0;
    endcase
  end

  assign bus.pcwrite    = ctrl.pcwrite;
  assign bus.memwrite   = ctrl.memwrite;
  assign bus.irwrite    = ctrl.irwrite;
  assign bus.regwrite   = ctrl.regwrite;
  assign bus.pcbufwrite = ctrl.pcbufwrite;
  assign bus.iord       = ctrl.iord;
  assign bus.alusrca    = ctrl.alusrca;
  assign bus.alusrcb    = ctrl.alusrcb;
  assign bus.regsrc     = ctrl.regsrc;
  assign bus.pcsrc      = ctrl.pcsrc;
  assign bus.branch     = ctrl.branch;
  assign bus.aluop      = ctrl.aluop;
  assign bus.rors       = ctrl.rors;
  assign bus.uart_go    = ctrl.uart_go;
  assign bus.halt       = (state_q == S_TRAP);
  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_maindec_param.sv
// Bench for maindec_param: three parameter sets, each driven with directed and random
// instructions and compared cycle by cycle against an instruction-level sequence model.
module tb_maindec_param;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, BR = 7'b1100011,
                         IT = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                         JAL = 7'b1101111, JALR = 7'b1100111, RECVB = 7'b0000001,
                         SENDB = 7'b0000010, ILL = 7'b1111111;

  typedef struct packed {
    logic       pcwrite, memwrite, irwrite, regwrite, pcbufwrite, iord;
    logic [1:0] alusrca, alusrcb;
    logic [2:0] regsrc;
    logic [1:0] pcsrc;
    logic       branch;
    logic [2:0] aluop;
    logic       rors, uart_go, halt;
    logic [1:0] trap_cause;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic done;
  } step_t;

  typedef enum {
    P_FETCH, P_FWAIT, P_FWAIT_LAST, P_DECODE, P_MEMADR, P_MEMREAD, P_MRWAIT, P_MEMWB,
    P_MEMWRITE, P_EXEC, P_ALUWB, P_BRANCH, P_IMMEX, P_IMMWB, P_LUI, P_AUIPC, P_JAL, P_JALR,
    P_SGO, P_SWAIT, P_RGO, P_RWAIT, P_RWRITE, P_TRAP_ILL, P_TRAP_UART
  } phase_t;

  logic       clk = 1'b0;
  logic [2:0] rst_v = 3'b111;
  logic [2:0] ud_v = 3'b000;
  logic [6:0] op_v [3];
  int lat [3] = '{2, 4, 3};
  int tmo [3] = '{0, 8, 5};
  int trp [3] = '{1, 1, 0};
  int checks = 0;
  int errors = 0;
  step_t q[$];

  always #5 clk = ~clk;

  maindec_param_if ifa ();
  maindec_param_if ifb ();
  maindec_param_if ifc ();

  assign ifa.op = op_v[0];  assign ifa.uart_done = ud_v[0];
  assign ifb.op = op_v[1];  assign ifb.uart_done = ud_v[1];
  assign ifc.op = op_v[2];  assign ifc.uart_done = ud_v[2];

  maindec_param #(.MEM_LAT(2), .UART_TIMEOUT(0), .TRAP_ON_ILLEGAL(1))
    dut_a (.clk(clk), .rst(rst_v[0]), .bus(ifa));
  maindec_param #(.MEM_LAT(4), .UART_TIMEOUT(8), .TRAP_ON_ILLEGAL(1))
    dut_b (.clk(clk), .rst(rst_v[1]), .bus(ifb));
  maindec_param #(.MEM_LAT(3), .UART_TIMEOUT(5), .TRAP_ON_ILLEGAL(0))
    dut_c (.clk(clk), .rst(rst_v[2]), .bus(ifc));

  function automatic obs_t get_obs(int d);
    case (d)
      0: return {ifa.pcwrite, ifa.memwrite, ifa.irwrite, ifa.regwrite, ifa.pcbufwrite, ifa.iord, ifa.alusrca, ifa.alusrcb, ifa.regsrc, ifa.pcsrc, ifa.branch, ifa.aluop, ifa.rors, ifa.uart_go, ifa.halt, ifa.trap_cause};
      1: return {ifb.pcwrite, ifb.memwrite, ifb.irwrite, ifb.regwrite, ifb.pcbufwrite, ifb.iord, ifb.alusrca, ifb.alusrcb, ifb.regsrc, ifb.pcsrc, ifb.branch, ifb.aluop, ifb.rors, ifb.uart_go, ifb.halt, ifb.trap_cause};
      default: return {ifc.pcwrite, ifc.memwrite, ifc.irwrite, ifc.regwrite, ifc.pcbufwrite, ifc.iord, ifc.alusrca, ifc.alusrcb, ifc.regsrc, ifc.pcsrc, ifc.branch, ifc.aluop, ifc.rors, ifc.uart_go, ifc.halt, ifc.trap_cause};
    endcase
  endfunction

  // Control table: what the datapath should see in each instruction phase.
  function automatic obs_t ctl(phase_t p);
    obs_t e;
    e = '0;
    case (p)
      P_FETCH:      begin e.pcwrite = 1'b1; e.pcbufwrite = 1'b1; e.alusrcb = 2'b01; end
      P_FWAIT_LAST: e.irwrite = 1'b1;
      P_DECODE:     begin e.alusrca = 2'b01; e.alusrcb = 2'b10; end
      P_MEMADR:     begin e.alusrca = 2'b10; e.alusrcb = 2'b10; end
      P_MEMREAD, P_MRWAIT: e.iord = 1'b1;
      P_MEMWB:      begin e.regwrite = 1'b1; e.regsrc = 3'b001; end
      P_MEMWRITE:   begin e.memwrite = 1'b1; e.iord = 1'b1; end
      P_EXEC:       begin e.alusrca = 2'b10; e.aluop = 3'b100; end
      P_ALUWB, P_IMMWB, P_AUIPC: e.regwrite = 1'b1;
      P_BRANCH:     begin e.alusrca = 2'b10; e.pcsrc = 2'b01; e.branch = 1'b1; e.aluop = 3'b111; end
      P_IMMEX:      begin e.alusrca = 2'b10; e.alusrcb = 2'b10; e.aluop = 3'b101; end
      P_LUI:        begin e.regwrite = 1'b1; e.regsrc = 3'b010; end
      P_JAL:        begin e.pcwrite = 1'b1; e.regwrite = 1'b1; e.regsrc = 3'b011; e.pcsrc = 2'b01; end
      P_JALR:       begin e.pcwrite = 1'b1; e.regwrite = 1'b1; e.alusrca = 2'b10; e.alusrcb = 2'b10;
                          e.regsrc = 3'b011; e.pcsrc = 2'b10; end
      P_SGO:        begin e.rors = 1'b1; e.uart_go = 1'b1; end
      P_SWAIT:      e.uart_go = 1'b1;
      P_RGO:        e.rors = 1'b1;
      P_RWRITE:     begin e.regwrite = 1'b1; e.regsrc = 3'b100; end
      P_TRAP_ILL:   begin e.halt = 1'b1; e.trap_cause = 2'b01; end
      P_TRAP_UART:  begin e.halt = 1'b1; e.trap_cause = 2'b10; end
      default:      e = '0;
    endcase
    return e;
  endfunction

  // uart_done outside the wait phases is random noise the decoder must ignore.
  task automatic push(phase_t p, logic done);
    step_t s;
    s.o = ctl(p);
    s.done = done;
    q.push_back(s);
  endtask

  task automatic push_n(phase_t p, int n);
    for (int i = 0; i < n; i++) push(p, 1'($urandom_range(0, 1)));
  endtask

  task automatic uart_wait(int d, phase_t wp, int done_at, int hold, output bit got, output bit trapped);
    got = 1'b0;
    trapped = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (k == done_at) begin push(wp, 1'b1); got = 1'b1; break; end
      push(wp, 1'b0);
      if (tmo[d] > 0 && k == tmo[d]) begin trapped = 1'b1; break; end
    end
    if (trapped) push_n(P_TRAP_UART, hold);
  endtask

  // Expected cycle sequence for one instruction, FETCH through its last cycle.
  task automatic plan(int d, logic [6:0] op, int done_at, int hold, output bit trapped);
    bit got;
    trapped = 1'b0;
    q.delete();
    push_n(P_FETCH, 1);
    push_n(P_FWAIT, lat[d] - 1);
    push_n(P_FWAIT_LAST, 1);
    push_n(P_DECODE, 1);
    case (op)
      LW:    begin push_n(P_MEMADR, 1); push_n(P_MEMREAD, 1); push_n(P_MRWAIT, lat[d]); push_n(P_MEMWB, 1); end
      SW:    begin push_n(P_MEMADR, 1); push_n(P_MEMWRITE, 1); end
      RT:    begin push_n(P_EXEC, 1); push_n(P_ALUWB, 1); end
      BR:    push_n(P_BRANCH, 1);
      IT:    begin push_n(P_IMMEX, 1); push_n(P_IMMWB, 1); end
      LUI:   push_n(P_LUI, 1);
      AUIPC: push_n(P_AUIPC, 1);
      JAL:   push_n(P_JAL, 1);
      JALR:  push_n(P_JALR, 1);
      SENDB: begin push_n(P_SGO, 1); uart_wait(d, P_SWAIT, done_at, hold, got, trapped); end
      RECVB: begin
        push_n(P_RGO, 1);
        uart_wait(d, P_RWAIT, done_at, hold, got, trapped);
        if (got) push_n(P_RWRITE, 1);
      end
      default: if (trp[d] != 0) begin trapped = 1'b1; push_n(P_TRAP_ILL, hold); end
    endcase
  endtask

  task automatic check(string tag, obs_t obs, obs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(int d, logic [6:0] op, int done_at, int hold, int limit, output bit trapped);
    int n;
    plan(d, op, done_at, hold, trapped);
    n = (limit < 0) ? q.size() : limit;
    for (int i = 0; i < n; i++) begin
      op_v[d] = op;
      ud_v[d] = q[i].done;
      @(negedge clk);
      check($sformatf("dut%0d op=%b step%0d", d, op, i), get_obs(d), q[i].o);
      @(posedge clk);
      #1;
    end
    ud_v[d] = 1'b0;
  endtask

  task automatic do_reset(int d);
    rst_v[d] = 1'b1;
    @(posedge clk);
    #1;
    rst_v[d] = 1'b0;
  endtask

  task automatic random_run(int d, int count);
    logic [6:0] legal [10] = '{LW, SW, RT, BR, IT, LUI, AUIPC, JAL, JALR, RECVB};
    logic [6:0] op;
    bit t;
    for (int i = 0; i < count; i++) begin
      case ($urandom_range(0, 11))
        10: op = SENDB;
        11: begin
          op = 7'($urandom_range(0, 127));
          while (op inside {LW, SW, RT, BR, IT, LUI, AUIPC, JAL, JALR, RECVB, SENDB})
            op = 7'($urandom_range(0, 127));
        end
        default: op = legal[$urandom_range(0, 9)];
      endcase
      run(d, op, int'($urandom_range(1, 10)), int'($urandom_range(1, 4)), -1, t);
      if (t) do_reset(d);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit t;
    for (int i = 0; i < 3; i++) op_v[i] = 7'd0;
    repeat (2) @(posedge clk);
    #1;

    // MEM_LAT=2, no UART timeout, illegal traps
    do_reset(0);
    run(0, RT, 0, 0, -1, t);
    run(0, SENDB, 5, 0, -1, t);
    run(0, ILL, 0, 100, -1, t);
    do_reset(0);
    random_run(0, 25);
    rst_v[0] = 1'b1;

    // MEM_LAT=4, UART_TIMEOUT=8
    do_reset(1);
    run(1, LW, 0, 0, -1, t);
    run(1, RECVB, 0, 5, -1, t);
    do_reset(1);
    run(1, RECVB, 8, 0, -1, t);
    run(1, LW, 0, 0, 9, t);
    do_reset(1);
    run(1, LW, 0, 0, -1, t);
    random_run(1, 25);
    rst_v[1] = 1'b1;

    // MEM_LAT=3, UART_TIMEOUT=5, illegal refetches
    do_reset(2);
    run(2, ILL, 0, 0, -1, t);
    run(2, RT, 0, 0, -1, t);
    random_run(2, 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
